// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder, sum = a + b + cin over WIDTH bits,
// DIGIT bits per clock with a registered ripple carry between digits.
// Valid/ready handshake on both sides, one operation in flight at a time.
//
// Optional build macro SERIAL_ADDER_OVF_EN adds the `ovf` output
// (two's-complement overflow of the completed add).
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for operands, in_ready=1
// S_RUN  | adding one DIGIT-wide slice per cycle, STEPS cycles total
// S_DONE | result presented with out_valid=1 until out_ready
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  generate
    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_adder: WIDTH (%0d) must be a positive multiple of DIGIT (%0d)",
             WIDTH, DIGIT);
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_accept;
  logic              w_run;
  logic              w_last_step;

  logic [WIDTH-1:0]  r_a_sh;
  logic [WIDTH-1:0]  r_b_sh;
  logic [WIDTH-1:0]  r_sum;
  logic              r_carry;
  logic              r_cout;
  logic [CNT_W-1:0]  r_cnt;

  logic [DIGIT:0]    w_digit;
  logic [WIDTH-1:0]  w_sum_nxt;

  // One DIGIT-wide slice of the add; top bit is the carry into the next slice.
  assign w_digit = {1'b0, r_a_sh[DIGIT-1:0]}
                 + {1'b0, r_b_sh[DIGIT-1:0]}
                 + {{DIGIT{1'b0}}, r_carry};

  // New slice enters at the top so the LSB slice ends up at bit 0 after STEPS shifts.
  generate
    if (DIGIT == WIDTH) begin : g_sum_single
      assign w_sum_nxt = w_digit[DIGIT-1:0];
    end else begin : g_sum_shift
      assign w_sum_nxt = {w_digit[DIGIT-1:0], r_sum[WIDTH-1:DIGIT]};
    end
  endgenerate

  assign w_run       = (r_state == S_RUN);
  assign w_last_step = w_run && (r_cnt == LAST_STEP);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake outputs; accept and result handshake live in different states.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (r_cnt == LAST_STEP) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Operand shift registers, ripple carry, step counter and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_a_sh  <= a;
      r_b_sh  <= b;
      r_carry <= cin;
      r_cnt   <= '0;
    end else if (w_run) begin
      r_a_sh  <= r_a_sh >> DIGIT;
      r_b_sh  <= r_b_sh >> DIGIT;
      r_sum   <= w_sum_nxt;
      r_carry <= w_digit[DIGIT];
      r_cnt   <= r_cnt + CNT_W'(1);
      if (w_last_step) begin
        r_cout <= w_digit[DIGIT];
      end
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;

`ifdef SERIAL_ADDER_OVF_EN
  logic r_ovf;
  logic w_ovf_step;

  // Carry into the MSB is recovered as a^b^s at the top bit of the last slice.
  assign w_ovf_step = r_a_sh[DIGIT-1] ^ r_b_sh[DIGIT-1]
                    ^ w_digit[DIGIT-1] ^ w_digit[DIGIT];

  // Overflow flag captured on the final slice and held with the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_last_step) begin
      r_ovf <= w_ovf_step;
    end
  end

  assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench for serial_adder in three configurations
// (W8/D1, W8/D4, W4/D1). Inputs change and outputs are sampled 1 time unit
// after the rising edge.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  // W=8, D=1
  logic       in_valid8 = 1'b0, out_ready8 = 1'b0, cin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       in_ready8, out_valid8, cout8, busy8;
  logic [7:0] sum8;
  // W=8, D=4
  logic       in_valid84 = 1'b0, out_ready84 = 1'b0, cin84 = 1'b0;
  logic [7:0] a84 = '0, b84 = '0;
  logic       in_ready84, out_valid84, cout84, busy84;
  logic [7:0] sum84;
  // W=4, D=1
  logic       in_valid4 = 1'b0, out_ready4 = 1'b0, cin4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       in_ready4, out_valid4, cout4, busy4;
  logic [3:0] sum4;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf8, ovf84, ovf4;
`endif

  // Scoreboards: {ovf, cout, sum}
  logic [9:0] sb8[$];
  logic [9:0] sb84[$];
  logic [5:0] sb4[$];

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_w8d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .cout(cout8), .busy(busy8)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf8)
`endif
  );

  serial_adder #(.WIDTH(8), .DIGIT(4)) u_w8d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid84), .in_ready(in_ready84),
    .a(a84), .b(b84), .cin(cin84), .out_valid(out_valid84), .out_ready(out_ready84),
    .sum(sum84), .cout(cout84), .busy(busy84)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf84)
`endif
  );

  serial_adder #(.WIDTH(4), .DIGIT(1)) u_w4d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .cin(cin4), .out_valid(out_valid4), .out_ready(out_ready4),
    .sum(sum4), .cout(cout4), .busy(busy4)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf4)
`endif
  );

  function automatic logic [9:0] model8(input logic [7:0] a, input logic [7:0] b,
                                        input logic c);
    logic [8:0] s;
    logic       v;
    s = {1'b0, a} + {1'b0, b} + {8'd0, c};
    v = (a[7] == b[7]) && (s[7] != a[7]);
    return {v, s};
  endfunction

  function automatic logic [5:0] model4(input logic [3:0] a, input logic [3:0] b,
                                        input logic c);
    logic [4:0] s;
    logic       v;
    s = {1'b0, a} + {1'b0, b} + {4'd0, c};
    v = (a[3] == b[3]) && (s[3] != a[3]);
    return {v, s};
  endfunction

  // Present one operand set to the W8/D1 instance and push its expected result.
  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic c);
    int n;
    n = 0;
    while (!in_ready8 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (in_ready8 !== 1'b1) begin
      failures++;
      $display("FAIL send8_ready_timeout: in_ready=%b required 1", in_ready8);
    end
    a8 = a; b8 = b; cin8 = c; in_valid8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    sb8.push_back(model8(a, b, c));
  endtask

  // Count cycles from the accepting edge until out_valid (bounded).
  task automatic wait8(output int lat);
    int n;
    n = 0;
    while (!out_valid8 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    lat = n;
  endtask

  task automatic ack8();
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready8 !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b required 1", in_ready8); end
    checks++; if (out_valid8 !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b required 0", out_valid8); end
    checks++; if (sum8 !== 8'h00) begin failures++; $display("FAIL reset_sum: got %h required 00", sum8); end
    checks++; if (cout8 !== 1'b0) begin failures++; $display("FAIL reset_cout: got %b required 0", cout8); end
    checks++; if (busy8 !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b required 0", busy8); end
    checks++; if ({in_ready84, in_ready4, out_valid84, out_valid4} !== 4'b1100) begin
      failures++; $display("FAIL reset_other_units: got %b required 1100", {in_ready84, in_ready4, out_valid84, out_valid4});
    end
`ifdef SERIAL_ADDER_OVF_EN
    checks++; if (ovf8 !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %b required 0", ovf8); end
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if ({in_ready8, busy8} !== 2'b10) begin failures++; $display("FAIL post_reset_idle: got %b required 10", {in_ready8, busy8}); end
  endtask

  task automatic test_add_d1();
    logic [16:0] ops [4];
    logic [9:0]  exp;
    int          lat;
    ops[0] = {8'h5A, 8'h33, 1'b0};
    ops[1] = {8'hFF, 8'h00, 1'b1};
    ops[2] = {8'h80, 8'h80, 1'b0};
    ops[3] = {8'h7F, 8'h00, 1'b1};
    for (int i = 0; i < 4; i++) begin
      send8(ops[i][16:9], ops[i][8:1], ops[i][0]);
      wait8(lat);
      checks++; if (lat !== 8) begin failures++; $display("FAIL d1_latency[%0d]: got %0d required 8", i, lat); end
      exp = sb8.pop_front();
      checks++; if (sum8 !== exp[7:0]) begin failures++; $display("FAIL d1_sum[%0d]: got %h required %h", i, sum8, exp[7:0]); end
      checks++; if (cout8 !== exp[8]) begin failures++; $display("FAIL d1_cout[%0d]: got %b required %b", i, cout8, exp[8]); end
`ifdef SERIAL_ADDER_OVF_EN
      checks++; if (ovf8 !== exp[9]) begin failures++; $display("FAIL d1_ovf[%0d]: got %b required %b", i, ovf8, exp[9]); end
`endif
      ack8();
      checks++; if ({out_valid8, in_ready8} !== 2'b01) begin failures++; $display("FAIL d1_after_ack[%0d]: got %b required 01", i, {out_valid8, in_ready8}); end
    end
  endtask

  task automatic test_add_d4();
    logic [16:0] ops [3];
    logic [9:0]  exp;
    int          n;
    ops[0] = {8'h99, 8'h88, 1'b1};
    ops[1] = {8'h7F, 8'h01, 1'b0};
    ops[2] = {8'hF0, 8'h0F, 1'b1};
    for (int i = 0; i < 3; i++) begin
      a84 = ops[i][16:9]; b84 = ops[i][8:1]; cin84 = ops[i][0]; in_valid84 = 1'b1;
      @(posedge clk); #1;
      in_valid84 = 1'b0;
      sb84.push_back(model8(ops[i][16:9], ops[i][8:1], ops[i][0]));
      n = 0;
      while (!out_valid84 && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      checks++; if (n !== 2) begin failures++; $display("FAIL d4_latency[%0d]: got %0d required 2", i, n); end
      exp = sb84.pop_front();
      checks++; if (sum84 !== exp[7:0]) begin failures++; $display("FAIL d4_sum[%0d]: got %h required %h", i, sum84, exp[7:0]); end
      checks++; if (cout84 !== exp[8]) begin failures++; $display("FAIL d4_cout[%0d]: got %b required %b", i, cout84, exp[8]); end
`ifdef SERIAL_ADDER_OVF_EN
      checks++; if (ovf84 !== exp[9]) begin failures++; $display("FAIL d4_ovf[%0d]: got %b required %b", i, ovf84, exp[9]); end
`endif
      checks++; if (in_ready84 !== 1'b0) begin failures++; $display("FAIL d4_in_ready_done[%0d]: got %b required 0", i, in_ready84); end
      out_ready84 = 1'b1;
      @(posedge clk); #1;
      out_ready84 = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    logic [9:0] exp;
    int         lat;
    send8(8'h3C, 8'h4B, 1'b1);
    wait8(lat);
    exp = sb8.pop_front();
    for (int k = 0; k < 5; k++) begin
      in_valid8 = k[0]; a8 = 8'hAA ^ k[7:0]; b8 = 8'h55; cin8 = 1'b1; out_ready8 = 1'b0;
      @(posedge clk); #1;
      checks++; if (out_valid8 !== 1'b1) begin failures++; $display("FAIL bp_out_valid[%0d]: got %b required 1", k, out_valid8); end
      checks++; if (sum8 !== exp[7:0]) begin failures++; $display("FAIL bp_sum[%0d]: got %h required %h", k, sum8, exp[7:0]); end
      checks++; if (cout8 !== exp[8]) begin failures++; $display("FAIL bp_cout[%0d]: got %b required %b", k, cout8, exp[8]); end
      checks++; if (in_ready8 !== 1'b0) begin failures++; $display("FAIL bp_in_ready[%0d]: got %b required 0", k, in_ready8); end
`ifdef SERIAL_ADDER_OVF_EN
      checks++; if (ovf8 !== exp[9]) begin failures++; $display("FAIL bp_ovf[%0d]: got %b required %b", k, ovf8, exp[9]); end
`endif
    end
    in_valid8 = 1'b0;
    ack8();
    checks++; if ({out_valid8, in_ready8} !== 2'b01) begin failures++; $display("FAIL bp_release: got %b required 01", {out_valid8, in_ready8}); end
    @(posedge clk); #1;
    checks++; if ({busy8, sum8} !== {1'b0, exp[7:0]}) begin
      failures++; $display("FAIL bp_no_stray_accept: busy/sum got %b/%h required 0/%h", busy8, sum8, exp[7:0]);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [9:0] exp;
    int         lat;
    send8(8'hFF, 8'h01, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid8 !== 1'b0) begin failures++; $display("FAIL rst_run_out_valid: got %b required 0", out_valid8); end
    checks++; if (sum8 !== 8'h00) begin failures++; $display("FAIL rst_run_sum: got %h required 00", sum8); end
    checks++; if (in_ready8 !== 1'b1) begin failures++; $display("FAIL rst_run_in_ready: got %b required 1", in_ready8); end
    checks++; if ({busy8, cout8} !== 2'b00) begin failures++; $display("FAIL rst_run_busy_cout: got %b required 00", {busy8, cout8}); end
    sb8.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send8(8'h01, 8'h01, 1'b0);
    wait8(lat);
    checks++; if (lat !== 8) begin failures++; $display("FAIL rst_next_latency: got %0d required 8", lat); end
    exp = sb8.pop_front();
    checks++; if ({cout8, sum8} !== exp[8:0]) begin failures++; $display("FAIL rst_next_result: got %b_%h required %b_%h", cout8, sum8, exp[8], exp[7:0]); end
    ack8();
  endtask

  task automatic test_exhaustive_w4();
    logic [8:0] v;
    logic [5:0] exp;
    logic       acc;
    int         idx, n_out, last_acc;
    idx = 0; n_out = 0; last_acc = -1;
    v = '0;
    a4 = v[8:5]; b4 = v[4:1]; cin4 = v[0];
    in_valid4 = 1'b1; out_ready4 = 1'b1;
    for (int c = 0; c < 512 * 6 + 20 && n_out < 512; c++) begin
      acc = in_ready4 && in_valid4;
      @(posedge clk); #1;
      if (acc) begin
        sb4.push_back(model4(v[8:5], v[4:1], v[0]));
        if (last_acc >= 0) begin
          checks++;
          if (c - last_acc !== 6) begin failures++; $display("FAIL w4_accept_gap[%0d]: got %0d required 6", idx, c - last_acc); end
        end
        last_acc = c;
        idx++;
        if (idx == 512) begin
          in_valid4 = 1'b0;
        end else begin
          v = idx[8:0];
          a4 = v[8:5]; b4 = v[4:1]; cin4 = v[0];
        end
      end
      if (out_valid4) begin
        checks++;
        if (sb4.size() == 0) begin
          failures++; $display("FAIL w4_unexpected_output: sum=%h cout=%b with no pending op", sum4, cout4);
        end else begin
          exp = sb4.pop_front();
          if ({cout4, sum4} !== exp[4:0]) begin
            failures++; $display("FAIL w4_result[%0d]: got %b_%h required %b_%h", n_out, cout4, sum4, exp[4], exp[3:0]);
          end
`ifdef SERIAL_ADDER_OVF_EN
          checks++;
          if (ovf4 !== exp[5]) begin failures++; $display("FAIL w4_ovf[%0d]: got %b required %b", n_out, ovf4, exp[5]); end
`endif
        end
        n_out++;
      end
    end
    in_valid4 = 1'b0; out_ready4 = 1'b0;
    checks++; if (n_out !== 512) begin failures++; $display("FAIL w4_completed: got %0d results required 512", n_out); end
  endtask

  initial begin
    test_reset();
    test_add_d1();
    test_add_d4();
    test_backpressure();
    test_reset_mid_run();
    test_exhaustive_w4();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
